seg_serial_tx: RTL and testbench
================================

# seg_serial_tx

Parallel-to-serial transmitter that drives the on-board daisy-chained 8-bit shift registers behind the eight seven-segment digits. It accepts one 64-bit segment frame, the same 64-bit segment image produced by the display decode stage, and shifts it out MSB first on a divided serial clock. It then pulses the register-chain latch and reports completion. It sits between the segment-image decode logic and the board pins `seg_clk`, `seg_sout`, `SEG_PEN` and `seg_clrn`.

## Interface
- `DATA_WIDTH`, 64, frame length in bits (multiple of 8, ≥ 8).
- `CLK_DIV`, 2, clk cycles per serial-clock half period (≥ 1).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `data`  in  DATA_WIDTH  frame; captured on the accepting edge only.
- `busy`  out  1  high from the cycle after acceptance until done.
- `done`  out  1  one-cycle completion pulse.
- `sout`  out  1  serial data to the chain.
- `sclk`  out  1  serial clock; the chain samples `sout` on the rising edge.
- `latch`  out  1  register-chain output-latch strobe (`SEG_PEN`), active high.
- `clrn`  out  1  active-low chain clear.

## Operation
- States: IDLE, SHIFT, LATCH.
- **Registered outputs.** All outputs are registered. No combinational path runs from input to output.
- **Reset values.** `busy`=0, `done`=0, `sout`=0, `sclk`=0, `latch`=0, `clrn`=0, state=IDLE, counters=0.
- **`clrn`.** Goes to 1 on the first clk edge after `rst` deasserts and stays 1 until the next reset.
- **IDLE.**
  - If `start`=1: copy `data` into the shift register, clear the bit and divider counters, and go to SHIFT.
  - Otherwise hold `sout`, `sclk` and `latch` at 0.
- **SHIFT.**
  - `sout` always equals the shift register MSB. The first bit presented is `data[DATA_WIDTH-1]`.
  - Each bit occupies 2·`CLK_DIV` cycles: `sclk`=0 for `CLK_DIV` cycles, then `sclk`=1 for `CLK_DIV` cycles.
  - When the high phase ends, `sclk` returns to 0. In the same cycle the register shifts left by 1, filling with 0, and the bit counter increments.
  - After bit index `DATA_WIDTH-1`'s high phase, go to LATCH. At that point `sclk`=0 and `sout`=0.
- **LATCH.** `latch`=1 and `sclk`=0 for `CLK_DIV` cycles. Then go to IDLE, asserting `done`=1 and `busy`=0 in that same cycle.
- **Capture and ignored inputs.**
  - `start` is ignored while `busy`=1.
  - Changes on `data` after acceptance have no effect on the frame.
- **Back-to-back frames.** `start`=1 in the cycle `done`=1 (IDLE) is accepted, so frames run back to back with no gap cycle.
- **Counter widths.**
  - Bit counter: ceil(log2(`DATA_WIDTH`+1)) bits.
  - Divider counter: ceil(log2(`CLK_DIV`+1)) bits.
  - Neither counter wraps inside a frame.
- **Reset mid-frame.** Outputs go to reset values immediately (asynchronous). No `done` is produced and the partial frame is discarded.

## Timing
Let N be the edge at which `start` is accepted; D = `CLK_DIV`, W = `DATA_WIDTH`.
- **Shifting, N+1 … N+2·D·W.**
  - `busy`=1 from N+1.
  - Bit k (k = 0 is the MSB) has `sclk`=0 in cycles N+1+2Dk … N+2Dk+D.
  - `sclk`=1 in cycles N+1+2Dk+D … N+2D(k+1).
  - `sout` is stable across the whole bit, including D cycles before and D cycles at the rising `sclk` edge (setup and hold margin = D cycles).
- **Latch.** `latch`=1 in cycles N+2DW+1 … N+2DW+D.
- **Done.** `done`=1 and `busy`=0 at N+2DW+D+1.
- **Total frame latency.** 2DW+D+1 cycles. With the defaults, done arrives 259 cycles after acceptance.
- **Pulse counts.** Exactly W rising `sclk` edges per frame and exactly one `latch` pulse.

## Test plan
1. **Reset:** assert `rst` asynchronously between clk edges → all outputs read reset values immediately; `clrn` rises on the first edge after release.
2. **Single-bit pattern:** defaults, `data`=64'h8000_0000_0000_0001, `start` for one cycle at N.
   - `sout`=1 for N+1…N+4, 0 for bits 1–62, 1 for N+253…N+256.
   - 64 `sclk` rising edges.
   - `latch`=1 at N+257…N+258.
   - `done` at N+259 only.
3. **Continuous start:** hold `start`=1 across two frames with `data`=64'hFFFF_0000_FFFF_0000.
   - The second frame's first bit appears at N+260.
   - Exactly two `done` pulses, at N+259 and N+518.
   - No third frame is accepted before N+518.
4. **Data stability:** change `data` to 64'h0 every cycle during busy → the shifted stream still matches the captured 64'hDEAD_BEEF_0123_4567 bit-for-bit.
5. **Reset mid-frame:** assert `rst` during bit 20.
   - No `done` and no `latch` pulse.
   - After release, a `start` with 64'h1234_5678_9ABC_DEF0 yields a complete, correct frame.
6. **Minimum divider:** `CLK_DIV`=1, `data`=64'hAAAA_AAAA_AAAA_AAAA.
   - `sclk` toggles every cycle.
   - `sout` alternates 1,0,… per bit.
   - `latch`=1 at N+129, `done` at N+130.

Source files
------------

// File: rtl/seg_serial_tx.sv
// rtl/seg_serial_tx.sv - parallel-to-serial transmitter for the seven-segment shift-register chain
//
// Shifts one DATA_WIDTH-bit segment frame out MSB first on a divided serial
// clock, pulses the chain latch, then reports completion.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  frame request, sampled only while idle
//   data   frame, captured on the accepting edge
//   busy   high from the cycle after acceptance until done
//   done   one-cycle completion pulse
//   sout   serial data to the chain
//   sclk   serial clock (chain samples sout on its rising edge)
//   latch  chain output-latch strobe, active high
//   clrn   active-low chain clear, released on the first edge after reset

module seg_serial_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic                  sout,
    output logic                  sclk,
    output logic                  latch,
    output logic                  clrn
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sout    <= 1'b0;
            sclk    <= 1'b0;
            latch   <= 1'b0;
            clrn    <= 1'b0;
        end else begin
            clrn <= 1'b1;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk  <= 1'b0;
                    latch <= 1'b0;
                    if (start) begin
                        // sout is registered, so present the MSB on the accepting edge
                        shreg   <= data;
                        sout    <= data[DATA_WIDTH-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        sout <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // end of the high phase: fall sclk and advance the bit together,
                            // which gives CLK_DIV cycles of hold after the rising edge
                            sclk    <= 1'b0;
                            shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            sout    <= shreg[DATA_WIDTH-2];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                sout  <= 1'b0;
                                latch <= 1'b1;
                                state <= LATCH;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        latch   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_tx.sv
// tb/tb_seg_serial_tx.sv - self-checking bench for seg_serial_tx against a cycle-offset frame model

module tb_seg_serial_tx;

    localparam int W  = 64;
    localparam int D0 = 2;
    localparam int D1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [63:0] data0 = '0, data1 = '0;
    logic        busy0, done0, sout0, sclk0, latch0, clrn0;
    logic        busy1, done1, sout1, sclk1, latch1, clrn1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    seg_serial_tx #(.DATA_WIDTH(W), .CLK_DIV(D0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data0),
        .busy(busy0), .done(done0), .sout(sout0), .sclk(sclk0), .latch(latch0), .clrn(clrn0)
    );

    seg_serial_tx #(.DATA_WIDTH(W), .CLK_DIV(D1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data1),
        .busy(busy1), .done(done1), .sout(sout1), .sclk(sclk1), .latch(latch1), .clrn(clrn1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {busy, done, sout, sclk, latch} at o cycles after the accepting cycle
    function automatic logic [4:0] exp_outs(input int o, input logic [63:0] fd, input int w, input int d);
        int t;
        int k;
        int pos;
        t = 2 * w * d;
        if (o >= 1 && o <= t) begin
            k   = (o - 1) / (2 * d);
            pos = (o - 1) % (2 * d);
            return {1'b1, 1'b0, fd[w-1-k], (pos >= d), 1'b0};
        end else if (o > t && o <= t + d) begin
            return 5'b10001;
        end else if (o == t + d + 1) begin
            return 5'b01000;
        end
        return 5'b00000;
    endfunction

    // Frame model: which frame (if any) each DUT is running and when it was accepted
    logic        active0 = 1'b0, active1 = 1'b0;
    int          n0_0 = 0, n0_1 = 0;
    logic [63:0] fd0 = '0, fd1 = '0;
    logic        clrn_m = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            active0 = 1'b0;
            active1 = 1'b0;
            clrn_m  = 1'b0;
        end else begin
            clrn_m = 1'b1;
            if ((!active0 || (cyc - 1 - n0_0) >= 2 * W * D0 + D0 + 1) && start0) begin
                active0 = 1'b1;
                n0_0    = cyc - 1;
                fd0     = data0;
            end
            if ((!active1 || (cyc - 1 - n0_1) >= 2 * W * D1 + D1 + 1) && start1) begin
                active1 = 1'b1;
                n0_1    = cyc - 1;
                fd1     = data1;
            end
        end
    end

    int   sclk_rise0 = 0, sclk_rise1 = 0, latch_rise0 = 0, latch_rise1 = 0;
    logic sclk0_p = 1'b0, sclk1_p = 1'b0, latch0_p = 1'b0, latch1_p = 1'b0;
    int   done_q0[$];
    int   done_q1[$];

    always @(negedge clk) begin
        logic [4:0] e0;
        logic [4:0] e1;
        if (rst) begin
            check("dut0_outs_rst", 64'({busy0, done0, sout0, sclk0, latch0, clrn0}), 64'd0);
            check("dut1_outs_rst", 64'({busy1, done1, sout1, sclk1, latch1, clrn1}), 64'd0);
        end else begin
            e0 = active0 ? exp_outs(cyc - n0_0, fd0, W, D0) : 5'b0;
            e1 = active1 ? exp_outs(cyc - n0_1, fd1, W, D1) : 5'b0;
            check("dut0_outs", 64'({busy0, done0, sout0, sclk0, latch0, clrn0}), 64'({e0, clrn_m}));
            check("dut1_outs", 64'({busy1, done1, sout1, sclk1, latch1, clrn1}), 64'({e1, clrn_m}));
        end
        if (sclk0 && !sclk0_p)   sclk_rise0++;
        if (sclk1 && !sclk1_p)   sclk_rise1++;
        if (latch0 && !latch0_p) latch_rise0++;
        if (latch1 && !latch1_p) latch_rise1++;
        if (done0) done_q0.push_back(cyc);
        if (done1) done_q1.push_back(cyc);
        sclk0_p  = sclk0;
        sclk1_p  = sclk1;
        latch0_p = latch0;
        latch1_p = latch1;
    end

    // Advance to just after the next falling edge(s); all stimulus changes happen there
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int sr;
        int lr;
        int base;
        int base1;

        // Reset and clrn release
        step(3);
        check("clrn_in_rst", 64'(clrn0), 64'd0);
        rst = 1'b0;
        #1;
        check("clrn_before_edge", 64'(clrn0), 64'd0);
        @(posedge clk);
        #1;
        check("clrn_rise0", 64'(clrn0), 64'd1);
        check("clrn_rise1", 64'(clrn1), 64'd1);
        step(2);

        // Single-bit pattern
        n = cyc; base = done_q0.size();
        start0 = 1'b1; data0 = 64'h8000_0000_0000_0001;
        step(1);
        start0 = 1'b0;
        sr = sclk_rise0; lr = latch_rise0;
        step(262);
        check("t2_sclk_rises", 64'(sclk_rise0 - sr), 64'd64);
        check("t2_latch_pulses", 64'(latch_rise0 - lr), 64'd1);
        check("t2_done_count", 64'(done_q0.size() - base), 64'd1);
        if (done_q0.size() > base) check("t2_done_cycle", 64'(done_q0[base]), 64'(n + 259));

        // Continuous start across two frames
        n = cyc; base = done_q0.size(); sr = sclk_rise0;
        start0 = 1'b1; data0 = 64'hFFFF_0000_FFFF_0000;
        step(518);
        start0 = 1'b0;
        step(10);
        check("t3_done_count", 64'(done_q0.size() - base), 64'd2);
        if (done_q0.size() > base + 1) begin
            check("t3_done1_cycle", 64'(done_q0[base]), 64'(n + 259));
            check("t3_done2_cycle", 64'(done_q0[base+1]), 64'(n + 518));
        end
        check("t3_sclk_rises", 64'(sclk_rise0 - sr), 64'd128);

        // Data changes after capture are ignored
        n = cyc; base = done_q0.size();
        start0 = 1'b1; data0 = 64'hDEAD_BEEF_0123_4567;
        step(1);
        start0 = 1'b0;
        for (int i = 0; i < 265; i++) begin
            data0 = (i % 2 == 0) ? 64'h0 : {$urandom, $urandom};
            step(1);
        end
        check("t4_done_count", 64'(done_q0.size() - base), 64'd1);
        if (done_q0.size() > base) check("t4_done_cycle", 64'(done_q0[base]), 64'(n + 259));

        // Reset during bit 20 (cycles N+81..N+84)
        n = cyc;
        start0 = 1'b1; data0 = {$urandom, $urandom};
        step(1);
        start0 = 1'b0;
        step(81);
        check("t5_busy_before_rst", 64'(busy0), 64'd1);
        base = done_q0.size(); lr = latch_rise0;
        rst = 1'b1;
        #1;
        check("t5_rst_async", 64'({busy0, done0, sout0, sclk0, latch0, clrn0}), 64'd0);
        step(3);
        rst = 1'b0;
        step(300);
        check("t5_no_done", 64'(done_q0.size() - base), 64'd0);
        check("t5_no_latch", 64'(latch_rise0 - lr), 64'd0);
        n = cyc; base = done_q0.size();
        start0 = 1'b1; data0 = 64'h1234_5678_9ABC_DEF0;
        step(1);
        start0 = 1'b0;
        step(262);
        check("t5_done_count", 64'(done_q0.size() - base), 64'd1);
        if (done_q0.size() > base) check("t5_done_cycle", 64'(done_q0[base]), 64'(n + 259));

        // Minimum divider instance
        n = cyc; base1 = done_q1.size(); sr = sclk_rise1; lr = latch_rise1;
        start1 = 1'b1; data1 = 64'hAAAA_AAAA_AAAA_AAAA;
        step(1);
        start1 = 1'b0;
        step(135);
        check("t6_sclk_rises", 64'(sclk_rise1 - sr), 64'd64);
        check("t6_latch_pulses", 64'(latch_rise1 - lr), 64'd1);
        check("t6_done_count", 64'(done_q1.size() - base1), 64'd1);
        if (done_q1.size() > base1) check("t6_done_cycle", 64'(done_q1[base1]), 64'(n + 130));

        // Random frames, random data churn and spurious start while busy
        for (int f = 0; f < 6; f++) begin
            step($urandom_range(0, 4));
            n = cyc; base = done_q0.size(); base1 = done_q1.size();
            start0 = 1'b1; data0 = {$urandom, $urandom};
            start1 = 1'b1; data1 = {$urandom, $urandom};
            step(1);
            for (int i = 1; i <= 262; i++) begin
                start0 = (i < 250) ? 1'($urandom % 2) : 1'b0;
                start1 = (i < 120) ? 1'($urandom % 2) : 1'b0;
                data0  = {$urandom, $urandom};
                data1  = {$urandom, $urandom};
                step(1);
            end
            check("rand_done0_count", 64'(done_q0.size() - base), 64'd1);
            check("rand_done1_count", 64'(done_q1.size() - base1), 64'd1);
            if (done_q0.size() > base) check("rand_done0_cycle", 64'(done_q0[base]), 64'(n + 259));
            if (done_q1.size() > base1) check("rand_done1_cycle", 64'(done_q1[base1]), 64'(n + 130));
        end

        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
